riscv_aes_ctrl: RTL and testbench

Sequencer between the AES operand register file and the AES round core.
- On an accepted start, snapshots the 128-bit state and key words and launches the core with a one-cycle pulse.
- Waits for core completion, with a timeout.
- Writes the 128-bit result back to memory as NUM_WORDS 32-bit stores on the core's data-bus port.
- Stalls the pipeline while active.

---
 rtl/riscv_aes_pkg.sv | 16 +
 rtl/riscv_aes_ctrl.sv | 159 +++++++++++++++
 tb/tb_riscv_aes_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_aes_pkg.sv
// Shared types and constants for the AES operand sequencer.
package riscv_aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_WORDS   = 4;
    localparam logic [3:0]  AES_BE_ALL  = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_CORE,
        WB_REQ,
        WB_RESP
    } aes_ctrl_state_e;

endpackage

// File: rtl/riscv_aes_ctrl.sv
// Sequencer between the AES operand register file and the AES round core:
// snapshot operands, launch the core, wait with timeout, store the result word by word.
module riscv_aes_ctrl
    import riscv_aes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = AES_WORDS,
    parameter int unsigned TIMEOUT_W  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            aes_start_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] state_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] key_i,
    input  logic [DATA_WIDTH-1:0]           wb_addr_i,
    output logic                            core_start_o,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] core_state_o,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] core_key_o,
    input  logic                            core_done_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] core_result_i,
    output logic                            data_req_o,
    input  logic                            data_gnt_i,
    input  logic                            data_rvalid_i,
    output logic [DATA_WIDTH-1:0]           data_addr_o,
    output logic                            data_we_o,
    output logic [3:0]                      data_be_o,
    output logic [DATA_WIDTH-1:0]           data_wdata_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o
);

    localparam int unsigned BLOCK_W = NUM_WORDS * DATA_WIDTH;
    localparam int unsigned KW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    aes_ctrl_state_e r_fsm, w_fsm_next;

    logic                  r_start_q;
    logic [BLOCK_W-1:0]    r_state;
    logic [BLOCK_W-1:0]    r_key;
    logic [BLOCK_W-1:0]    r_result;
    logic [DATA_WIDTH-1:0] r_base;
    logic [KW-1:0]         r_k;
    logic [TIMEOUT_W-1:0]  r_tmo;
    logic                  r_done;
    logic                  r_error;

    logic                  w_start_edge;
    logic                  w_accept;
    logic                  w_tmo_hit;
    logic                  w_done_set;
    logic                  w_last;
    logic [TIMEOUT_W-1:0]  w_tmo_inc;
    logic [DATA_WIDTH-1:0] w_res_words [NUM_WORDS];
    logic                  w_unused_addr_lsb;

    assign w_start_edge      = aes_start_i & ~r_start_q;
    assign w_tmo_inc         = r_tmo + TIMEOUT_W'(1);
    assign w_last            = (r_k == KW'(NUM_WORDS - 1));
    assign w_unused_addr_lsb = ^wb_addr_i[1:0];

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_words
        assign w_res_words[g] = r_result[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        w_fsm_next = r_fsm;
        w_accept   = 1'b0;
        w_tmo_hit  = 1'b0;
        w_done_set = 1'b0;
        unique case (r_fsm)
            IDLE: begin
                if (w_start_edge) begin
                    w_accept   = 1'b1;
                    w_fsm_next = LAUNCH;
                end
            end
            LAUNCH: w_fsm_next = WAIT_CORE;
            WAIT_CORE: begin
                // A completion in the final counted cycle still wins over the timeout.
                if (core_done_i) begin
                    w_fsm_next = WB_REQ;
                end else if (w_tmo_inc == '1) begin
                    w_tmo_hit  = 1'b1;
                    w_fsm_next = IDLE;
                end
            end
            WB_REQ: begin
                if (data_gnt_i) begin
                    w_fsm_next = WB_RESP;
                end
            end
            WB_RESP: begin
                if (data_rvalid_i) begin
                    if (w_last) begin
                        w_done_set = 1'b1;
                        w_fsm_next = IDLE;
                    end else begin
                        w_fsm_next = WB_REQ;
                    end
                end
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm     <= IDLE;
            r_start_q <= 1'b0;
            r_state   <= '0;
            r_key     <= '0;
            r_result  <= '0;
            r_base    <= '0;
            r_k       <= '0;
            r_tmo     <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_fsm     <= w_fsm_next;
            r_start_q <= aes_start_i;
            r_done    <= w_done_set;
            if (w_accept) begin
                r_state <= state_i;
                r_key   <= key_i;
                r_base  <= {wb_addr_i[DATA_WIDTH-1:2], 2'b00};
                r_error <= 1'b0;
            end else if (w_tmo_hit) begin
                r_error <= 1'b1;
            end
            if (r_fsm == LAUNCH) begin
                r_tmo <= '0;
            end else if (r_fsm == WAIT_CORE) begin
                r_tmo <= w_tmo_inc;
            end
            if (r_fsm == WAIT_CORE && core_done_i) begin
                r_result <= core_result_i;
                r_k      <= '0;
            end else if (r_fsm == WB_RESP && data_rvalid_i && !w_last) begin
                r_k <= r_k + KW'(1);
            end
        end
    end

    assign core_start_o = (r_fsm == LAUNCH);
    assign core_state_o = r_state;
    assign core_key_o   = r_key;
    assign busy_o       = (r_fsm != IDLE);
    assign done_o       = r_done;
    assign error_o      = r_error;

    // Bus outputs are zero outside WB_REQ so they stay quiet while idle or in reset.
    assign data_req_o   = (r_fsm == WB_REQ);
    assign data_we_o    = data_req_o;
    assign data_be_o    = data_req_o ? AES_BE_ALL : 4'h0;
    assign data_addr_o  = data_req_o ? (r_base + (DATA_WIDTH'(r_k) << 2)) : '0;
    assign data_wdata_o = data_req_o ? w_res_words[r_k] : '0;

endmodule

// File: tb/tb_riscv_aes_ctrl.sv
// Self-checking bench for riscv_aes_ctrl: directed table, hand sequences and random transactions.
module tb_riscv_aes_ctrl;

    localparam int TW  = 4;
    localparam int TMO = (1 << TW) - 1;

    logic         clk;
    logic         rst_n;
    logic         aes_start_i;
    logic [127:0] state_i;
    logic [127:0] key_i;
    logic [31:0]  wb_addr_i;
    logic         core_start_o;
    logic [127:0] core_state_o;
    logic [127:0] core_key_o;
    logic         core_done_i;
    logic [127:0] core_result_i;
    logic         data_req_o;
    logic         data_gnt_i;
    logic         data_rvalid_i;
    logic [31:0]  data_addr_o;
    logic         data_we_o;
    logic [3:0]   data_be_o;
    logic [31:0]  data_wdata_o;
    logic         busy_o;
    logic         done_o;
    logic         error_o;

    int n_chk  = 0;
    int n_pass = 0;

    riscv_aes_ctrl #(
        .DATA_WIDTH(32),
        .NUM_WORDS (4),
        .TIMEOUT_W (TW)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .aes_start_i  (aes_start_i),
        .state_i      (state_i),
        .key_i        (key_i),
        .wb_addr_i    (wb_addr_i),
        .core_start_o (core_start_o),
        .core_state_o (core_state_o),
        .core_key_o   (core_key_o),
        .core_done_i  (core_done_i),
        .core_result_i(core_result_i),
        .data_req_o   (data_req_o),
        .data_gnt_i   (data_gnt_i),
        .data_rvalid_i(data_rvalid_i),
        .data_addr_o  (data_addr_o),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_wdata_o (data_wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [127:0] st;
        logic [127:0] ky;
        logic [127:0] res;
        logic [31:0]  addr;
        int           lat;
        int           stall_word;
        int           stall_n;
        bit           hold;
        bit           glitch;
        bit           exp_err;
        logic [31:0]  exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: stores go to the word-aligned base plus 4 per word, wrapping at 2**32.
    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
        logic [31:0] aligned;
        aligned = base & 32'hFFFF_FFFC;
        return aligned + 32'(4 * k);
    endfunction

    function automatic logic [31:0] exp_word(input logic [127:0] r, input int k);
        return r[32*k +: 32];
    endfunction

    task automatic run_txn(input logic [127:0] st, input logic [127:0] ky,
                           input logic [127:0] res, input logic [31:0] ad, input int lat,
                           input int stall_word, input int stall_n, input bit hold,
                           input bit glitch, input string tag, output logic [31:0] last_addr);
        bit got;
        bit wait_bad;
        int nst;
        int nrv;
        last_addr     = '0;
        state_i       = st;
        key_i         = ky;
        wb_addr_i     = ad;
        aes_start_i   = 1'b1;
        tick;
        chk({tag, "/launch"}, core_start_o, 1'b1);
        chk({tag, "/busy_launch"}, busy_o, 1'b1);
        chk({tag, "/snap_state"}, core_state_o, st);
        chk({tag, "/snap_key"}, core_key_o, ky);
        chk({tag, "/err_cleared"}, error_o, 1'b0);
        state_i   = ~st;
        key_i     = ~ky;
        wb_addr_i = ~ad;
        if (!hold) aes_start_i = 1'b0;
        got      = 1'b0;
        wait_bad = 1'b0;
        for (int i = 1; i <= TMO; i++) begin
            tick;
            if (core_start_o || data_req_o || !busy_o || done_o) wait_bad = 1'b1;
            if (glitch && i == 2) aes_start_i = 1'b0;
            if (glitch && i == 3) aes_start_i = 1'b1;
            if (i == lat) begin
                core_done_i   = 1'b1;
                core_result_i = res;
                tick;
                core_done_i   = 1'b0;
                core_result_i = {$urandom, $urandom, $urandom, $urandom};
                got = 1'b1;
                break;
            end
        end
        chk({tag, "/wait_quiet"}, wait_bad, 1'b0);
        if (!got) begin
            tick;
            chk({tag, "/tmo_err"}, error_o, 1'b1);
            chk({tag, "/tmo_busy"}, busy_o, 1'b0);
            chk({tag, "/tmo_noreq"}, data_req_o, 1'b0);
            chk({tag, "/tmo_nodone"}, done_o, 1'b0);
            tick;
            chk({tag, "/tmo_sticky"}, error_o, 1'b1);
        end else begin
            for (int k = 0; k < 4; k++) begin
                nst = (k == stall_word) ? stall_n : int'($urandom_range(0, 2));
                for (int s = 0; s <= nst; s++) begin
                    chk({tag, "/req"}, data_req_o, 1'b1);
                    chk({tag, "/addr"}, data_addr_o, exp_addr(ad, k));
                    chk({tag, "/wdata"}, data_wdata_o, exp_word(res, k));
                    chk({tag, "/we_be"}, {data_we_o, data_be_o}, 5'h1F);
                    last_addr     = data_addr_o;
                    data_gnt_i    = (s == nst);
                    data_rvalid_i = (s == nst) && ($urandom_range(0, 1) == 1);
                    if ($urandom_range(0, 3) == 0) begin
                        core_done_i   = 1'b1;
                        core_result_i = ~res;
                    end
                    tick;
                    data_gnt_i    = 1'b0;
                    data_rvalid_i = 1'b0;
                    core_done_i   = 1'b0;
                end
                nrv = $urandom_range(0, 2);
                for (int r = 0; r <= nrv; r++) begin
                    chk({tag, "/resp_noreq"}, data_req_o, 1'b0);
                    chk({tag, "/resp_busy_nodone"}, {busy_o, done_o}, 2'b10);
                    data_rvalid_i = (r == nrv);
                    tick;
                    data_rvalid_i = 1'b0;
                end
            end
            chk({tag, "/done"}, done_o, 1'b1);
            chk({tag, "/done_idle"}, {busy_o, data_req_o}, 2'b00);
            tick;
            chk({tag, "/done_pulse"}, done_o, 1'b0);
        end
        if (hold) begin
            for (int j = 0; j < 3; j++) begin
                chk({tag, "/no_relaunch"}, {core_start_o, busy_o}, 2'b00);
                tick;
            end
        end
        aes_start_i = 1'b0;
        tick;
    endtask

    vec_t        tbl [8];
    logic [31:0] la;
    vec_t        v;

    initial begin
        tbl[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 32'h1000_0002, 11, -1, 0, 1'b0, 1'b0,
                   1'b0, 32'h1000_000C};
        tbl[1] = '{128'hdeadbeef_01234567_89abcdef_cafef00d, 128'h1, 128'h44444444_33333333_22222222_11111111,
                   32'h2000_0010, 3, 2, 5, 1'b0, 1'b0, 1'b0, 32'h2000_001C};
        tbl[2] = '{128'h5, 128'h6, 128'h7, 32'h2222_0000, 0, -1, 0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[3] = '{128'h8, 128'h9, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 32'h0000_0100, 1, -1, 0,
                   1'b0, 1'b0, 1'b0, 32'h0000_010C};
        tbl[4] = '{128'h11, 128'h22, 128'h0badf00d_0badf00d_12345678_87654321, 32'h3000_0007, 11, -1,
                   0, 1'b1, 1'b1, 1'b0, 32'h3000_0010};
        tbl[5] = '{128'h33, 128'h44, 128'hffffffff_eeeeeeee_dddddddd_cccccccc, 32'hFFFF_FFF8, 5, -1, 0,
                   1'b0, 1'b0, 1'b0, 32'h0000_0004};
        tbl[6] = '{128'h55, 128'h66, 128'h13579bdf_2468ace0_fedcba98_76543210, 32'h4000_0000, TMO, -1,
                   0, 1'b0, 1'b0, 1'b0, 32'h4000_000C};
        tbl[7] = '{128'h77, 128'h88, 128'h99, 32'h5000_0000, TMO + 1, -1, 0, 1'b0, 1'b0, 1'b1, 32'h0};

        rst_n         = 1'b0;
        aes_start_i   = 1'b0;
        state_i       = '0;
        key_i         = '0;
        wb_addr_i     = '0;
        core_done_i   = 1'b0;
        core_result_i = '0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        tick;
        tick;
        chk("reset/ctrl", {busy_o, done_o, error_o, core_start_o, data_req_o, data_we_o}, 6'b0);
        chk("reset/snap", {core_state_o, core_key_o}, 256'b0);
        chk("reset/bus", {data_addr_o, data_wdata_o, data_be_o}, 68'b0);
        rst_n = 1'b1;
        tick;
        chk("reset/idle", busy_o, 1'b0);

        for (int t = 0; t < 8; t++) begin
            v = tbl[t];
            run_txn(v.st, v.ky, v.res, v.addr, v.lat, v.stall_word, v.stall_n, v.hold, v.glitch,
                    $sformatf("vec%0d", t), la);
            chk($sformatf("vec%0d/err", t), error_o, v.exp_err);
            chk($sformatf("vec%0d/last_addr", t), la, v.exp_last);
        end

        // Asynchronous reset while a store request is pending.
        state_i     = 128'h1234;
        key_i       = 128'h5678;
        wb_addr_i   = 32'h6000_0000;
        aes_start_i = 1'b1;
        tick;
        aes_start_i = 1'b0;
        tick;
        core_done_i   = 1'b1;
        core_result_i = 128'hcafe;
        tick;
        core_done_i = 1'b0;
        chk("rst_mid/req_before", data_req_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid/ctrl", {busy_o, done_o, error_o, core_start_o, data_req_o, data_we_o}, 6'b0);
        chk("rst_mid/bus", {data_addr_o, data_wdata_o, data_be_o}, 68'b0);
        chk("rst_mid/snap", {core_state_o, core_key_o}, 256'b0);
        tick;
        rst_n = 1'b1;
        tick;
        run_txn(128'hfeed, 128'hbeef, 128'h0c0ffee0_11112222_33334444_55556666, 32'h7000_0004, 4,
                -1, 0, 1'b0, 1'b0, "post_rst", la);
        chk("post_rst/last_addr", la, 32'h7000_0010);

        for (int t = 0; t < 20; t++) begin
            logic [127:0] rst_v;
            logic [127:0] rky;
            logic [127:0] rres;
            logic [31:0]  rad;
            int           rlat;
            rst_v = {$urandom, $urandom, $urandom, $urandom};
            rky   = {$urandom, $urandom, $urandom, $urandom};
            rres  = {$urandom, $urandom, $urandom, $urandom};
            rad   = $urandom;
            rlat  = $urandom_range(1, TMO + 2);
            run_txn(rst_v, rky, rres, rad, rlat, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), 1'b0, 1'b0, $sformatf("rnd%0d", t), la);
            chk($sformatf("rnd%0d/err", t), error_o, (rlat > TMO));
            chk($sformatf("rnd%0d/last_addr", t), la, (rlat > TMO) ? 32'h0 : exp_addr(rad, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
